// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream handshake plus instruction RAM write port of the boot loader.
// The loader uses the slave modport; the byte source and RAM side use master.
interface instr_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
   logic [7:0]            iByte;
   logic                  iByteValid;
   logic                  oByteReady;
   logic                  iReload;
   logic                  oWriteEnable;
   logic [ADDR_WIDTH-1:0] oAddress;
   logic [DATA_WIDTH-1:0] oData;
   logic                  oCpuReset;
   logic                  oDone;
   logic                  oError;
   modport master (
      output iByte, iByteValid, iReload,
      input  oByteReady, oWriteEnable, oAddress, oData, oCpuReset, oDone, oError
   );
   modport slave (
      input  iByte, iByteValid, iReload,
      output oByteReady, oWriteEnable, oAddress, oData, oCpuReset, oDone, oError
   );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: assembles a counted byte stream into 16-bit instruction RAM writes, holding the CPU in reset until done.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte (mismatch -> ERROR).
module instr_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
   input logic Clock,
   input logic Reset,
   instr_loader_if.slave bus
);
   typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, WRITE, DONE, ERROR} state_t;
`ifdef LOADER_CHECKSUM_EN
   localparam state_t FINISH = CHECK;
`else
   localparam state_t FINISH = DONE;
`endif
   state_t state, nextState;
   logic [ADDR_WIDTH-1:0] cnt, idx;
   logic [7:0] hiByte;
   logic [DATA_WIDTH-1:0] word;
   logic take;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum;
`endif
   assign take = bus.iByteValid && bus.oByteReady;
   assign word = {hiByte, bus.iByte};
   assign bus.oByteReady = state inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
   assign bus.oWriteEnable = state == WRITE;
   assign bus.oCpuReset = state != DONE;
   assign bus.oDone = state == DONE;
`ifdef LOADER_CHECKSUM_EN
   assign bus.oError = state == ERROR;
`else
   assign bus.oError = 1'b0;
`endif
   always_comb begin
      nextState = state;
      case (state)
         CNT_HI:  nextState = take ? CNT_LO : state;
         CNT_LO:  nextState = !take ? state : ({cnt[ADDR_WIDTH-1:8], bus.iByte} == '0) ? FINISH : DATA_HI;
         DATA_HI: nextState = take ? DATA_LO : state;
         DATA_LO: nextState = take ? WRITE : state;
         WRITE:   nextState = (idx == cnt - 1'b1) ? FINISH : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
         CHECK:   nextState = !take ? state : (bus.iByte == sum) ? DONE : ERROR;
`endif
         DONE, ERROR: nextState = bus.iReload ? CNT_HI : state;
         default: nextState = CNT_HI;
      endcase
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= CNT_HI;
         cnt <= '0;
         idx <= '0;
         hiByte <= '0;
         bus.oAddress <= '0;
         bus.oData <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum <= '0;
`endif
      end else begin
         state <= nextState;
         if (take && state == CNT_HI) cnt[ADDR_WIDTH-1:8] <= bus.iByte[ADDR_WIDTH-9:0];
         if (take && state == CNT_LO) cnt[7:0] <= bus.iByte;
         if (take && state == DATA_HI) hiByte <= bus.iByte;
         if (take && state == DATA_LO) begin
            bus.oAddress <= idx;
            bus.oData <= word;
         end
         // Index and checksum restart whenever a new load begins.
         if (nextState == CNT_HI) idx <= '0;
         else if (state == WRITE) idx <= idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
         if (nextState == CNT_HI) sum <= '0;
         else if (take && state != CHECK) sum <= sum + bus.iByte;
`endif
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench; a byte-stream model predicts every write, its timing and the end state.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_instr_loader;
   logic clock = 1'b0;
   logic reset;
   int nChecks = 0;
   int nFails = 0;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   instr_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();
   instr_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (.Clock(clock), .Reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic run_load(input string name, input logic [15:0] words[$], input int maxGap, input bit badSum, input bit noise);
      logic [7:0] q[$];
      logic [7:0] sum = 8'h00;
      int n = words.size();
      int pos = 0, wi = 0, cyc = 0, pend = -1, lastW = -1, lastD = -1, gap, limit, expT;
      bit fin = 1'b0;
      q.push_back({noise ? 6'($urandom) : 6'd0, 2'(n >> 8)});
      q.push_back(8'(n));
      foreach (words[i]) begin
         q.push_back(words[i][15:8]);
         q.push_back(words[i][7:0]);
      end
      foreach (q[i]) sum = sum + q[i];
      if (CHK) q.push_back(sum + 8'(badSum));
      limit = 8 * q.size() + 40;
      gap = $urandom_range(0, maxGap);
      while (!fin && cyc < limit) begin
         @(negedge clock);
         cyc++;
         if (bus.oWriteEnable) begin
            nChecks++;
            if (wi >= n || cyc != pend || bus.oAddress !== 10'(wi) || bus.oData !== words[wi]) begin
               nFails++;
               $display("FAIL %s write%0d: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d (words=%0d)",
                        name, wi, bus.oAddress, bus.oData, cyc, 10'(wi), (wi < n) ? words[wi] : 16'hxxxx, pend, n);
            end
            wi++;
            lastW = cyc;
         end
         if (bus.oDone || bus.oError) begin
            fin = 1'b1;
            bus.iReload = 1'b0;
            bus.iByteValid = 1'b0;
         end else begin
            nChecks++;
            if (bus.oCpuReset !== 1'b1) begin
               nFails++;
               $display("FAIL %s cpuReset during load: got %b, required 1 (cycle %0d)", name, bus.oCpuReset, cyc);
            end
            bus.iReload = noise && ($urandom_range(0, 3) == 0);
            if (gap > 0 || pos >= q.size()) begin
               bus.iByteValid = 1'b0;
               bus.iByte = 8'($urandom);
               if (gap > 0) gap--;
            end else begin
               bus.iByteValid = 1'b1;
               bus.iByte = q[pos];
               if (bus.oByteReady) begin
                  if (pos >= 2 && pos < 2 + 2 * n && pos % 2 == 1) pend = cyc + 1;
                  lastD = cyc;
                  pos++;
                  gap = $urandom_range(0, maxGap);
               end
            end
         end
      end
      expT = (n > 0 && !CHK) ? lastW + 1 : lastD + 1;
      nChecks++;
      if (!fin || cyc != expT || wi != n || pos != q.size()) begin
         nFails++;
         $display("FAIL %s completion: got finished=%0d cycle=%0d writes=%0d bytes=%0d, required finished=1 cycle=%0d writes=%0d bytes=%0d",
                  name, fin, cyc, wi, pos, expT, n, q.size());
      end
      repeat (2) begin
         nChecks++;
         if (CHK && badSum) begin
            if (bus.oError !== 1'b1 || bus.oDone !== 1'b0 || bus.oCpuReset !== 1'b1 || bus.oByteReady !== 1'b0) begin
               nFails++;
               $display("FAIL %s error state: got err=%b done=%b cpuRst=%b ready=%b, required 1 0 1 0",
                        name, bus.oError, bus.oDone, bus.oCpuReset, bus.oByteReady);
            end
         end else if (bus.oDone !== 1'b1 || bus.oError !== 1'b0 || bus.oCpuReset !== 1'b0 || bus.oByteReady !== 1'b0) begin
            nFails++;
            $display("FAIL %s done state: got done=%b err=%b cpuRst=%b ready=%b, required 1 0 0 0",
                     name, bus.oDone, bus.oError, bus.oCpuReset, bus.oByteReady);
         end
         @(negedge clock);
      end
   endtask

   task automatic do_reload(input string name);
      bus.iReload = 1'b1;
      @(negedge clock);
      bus.iReload = 1'b0;
      nChecks++;
      if (bus.oDone !== 1'b0 || bus.oError !== 1'b0 || bus.oCpuReset !== 1'b1 || bus.oByteReady !== 1'b1) begin
         nFails++;
         $display("FAIL %s reload: got done=%b err=%b cpuRst=%b ready=%b, required 0 0 1 1",
                  name, bus.oDone, bus.oError, bus.oCpuReset, bus.oByteReady);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.iByte = 8'h00;
      bus.iByteValid = 1'b0;
      bus.iReload = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      nChecks++;
      if (bus.oWriteEnable !== 1'b0 || bus.oAddress !== 10'h0 || bus.oData !== 16'h0 || bus.oCpuReset !== 1'b1 ||
          bus.oDone !== 1'b0 || bus.oError !== 1'b0 || bus.oByteReady !== 1'b1) begin
         nFails++;
         $display("FAIL reset: got we=%b addr=%h data=%h cpuRst=%b done=%b err=%b ready=%b, required 0 000 0000 1 0 0 1",
                  bus.oWriteEnable, bus.oAddress, bus.oData, bus.oCpuReset, bus.oDone, bus.oError, bus.oByteReady);
      end
   endtask

   task automatic test_basic();
      run_load("basic", '{16'h1234, 16'hABCD}, 0, 1'b0, 1'b0);
   endtask

   task automatic test_zero_count();
      do_reload("zero");
      run_load("zero", '{}, 0, 1'b0, 1'b0);
   endtask

   task automatic test_gapped();
      do_reload("gapped");
      run_load("gapped", '{16'h1234, 16'hABCD}, 3, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] hdr[3] = '{8'h00, 8'h02, 8'h12};
      do_reload("resetMid");
      foreach (hdr[i]) begin
         bus.iByteValid = 1'b1;
         bus.iByte = hdr[i];
         @(negedge clock);
      end
      bus.iByte = 8'h34;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.iByteValid = 1'b0;
      nChecks++;
      if (bus.oWriteEnable !== 1'b0 || bus.oAddress !== 10'h0 || bus.oData !== 16'h0 || bus.oCpuReset !== 1'b1 ||
          bus.oDone !== 1'b0 || bus.oByteReady !== 1'b1) begin
         nFails++;
         $display("FAIL resetMid: got we=%b addr=%h data=%h cpuRst=%b done=%b ready=%b, required 0 000 0000 1 0 1",
                  bus.oWriteEnable, bus.oAddress, bus.oData, bus.oCpuReset, bus.oDone, bus.oByteReady);
      end
      @(negedge clock);
      nChecks++;
      if (bus.oWriteEnable !== 1'b0) begin
         nFails++;
         $display("FAIL resetMid late write: got we=%b, required 0", bus.oWriteEnable);
      end
      run_load("resetMidFresh", '{16'h5A5A, 16'h0F0F, 16'hC3C3}, 1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 5; t++) begin
         logic [15:0] w[$];
         int n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) w.push_back(16'($urandom));
         do_reload("random");
         run_load($sformatf("random%0d", t), w, $urandom_range(0, 3), 1'b0, 1'b1);
      end
   endtask

   task automatic test_checksum();
      do_reload("checksumGood");
      run_load("checksumGood", '{16'h1234}, 0, 1'b0, 1'b0);
      do_reload("checksumBad");
      run_load("checksumBad", '{16'h1234}, 0, 1'b1, 1'b0);
      do_reload("checksumAfterErr");
      run_load("checksumRandomBad", '{16'hBEEF, 16'h0001}, 2, 1'b1, 1'b1);
      do_reload("checksumRecover");
   endtask

   task automatic test_full();
      logic [15:0] w[$];
      for (int i = 0; i < 1023; i++) w.push_back(16'(i));
      do_reload("full");
      run_load("full", w, 0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_gapped();
      test_reset_mid_load();
      test_random();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_full();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
